// File: rtl/ibus_read_arbiter.sv
// ibus_read_arbiter: round-robin arbiter sequencing single-word reads from the register read unit
module ibus_read_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 2,
  parameter int TURN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [15:0]       rdata,
  output logic              nruen,
  output logic [4:0]        raddr,
  input  logic [15:0]       ibus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2((HOLD > TURN ? HOLD : TURN) + 1);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic [IW:0] s;
  logic [CW-1:0] cnt;
  // scan downward so the lowest offset from ptr is the last (winning) assignment
  always_comb begin
    pick = '0;
    s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = (s >= (IW+1)'(NREQ)) ? s - (IW+1)'(NREQ) : s;
      pick = req[s[IW-1:0]] ? s[IW-1:0] : pick;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      nruen <= 1'b1;
      raddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          if (|req) begin
            raddr <= req_addr[5*pick +: 5];
            gnt   <= NREQ'(1) << pick;
            nruen <= 1'b0;
            cnt   <= CW'(HOLD - 1);
            ptr   <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == '0) begin
            rdata <= ibus;
            done  <= gnt;
            gnt   <= '0;
            nruen <= 1'b1;
            cnt   <= CW'(TURN - 1);
            state <= S_TURN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          done  <= '0;
          cnt   <= (cnt == '0) ? cnt : cnt - 1'b1;
          state <= (cnt == '0) ? S_IDLE : S_TURN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ibus_read_arbiter.sv
// tb_ibus_read_arbiter: scoreboard bench with a behavioural constant-store model on ibus
module tb_ibus_read_arbiter;
  localparam int NREQ = 4;
  localparam int HOLD = 2;
  localparam int TURN = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [5*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0] gnt, done;
  logic [15:0] rdata, ibus;
  logic nruen;
  logic [4:0] raddr;
  logic [15:0] zw = 16'hzzzz;
  typedef struct {int idx; logic [4:0] addr; logic [15:0] data;} exp_t;
  exp_t q[$];
  int done_cyc[$];
  int ncmp = 0, nerr = 0, cyc = 0, ndone = 0;
  int low_run = 0, high_run = 0;
  bit seen_low = 0, auto_drop = 1;
  logic prev_nruen = 1'b1;
  logic [4:0] prev_raddr = '0;
  logic [NREQ-1:0] prev_gnt = '0;

  ibus_read_arbiter #(.NREQ(NREQ), .HOLD(HOLD), .TURN(TURN)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt), .done(done),
    .rdata(rdata), .nruen(nruen), .raddr(raddr), .ibus(ibus)
  );

  // constant store: slots 4..7 hold 0..3, anything else leaves the bus floating
  assign ibus = (!nruen && raddr[4:2] == 3'b001) ? {14'b0, raddr[1:0]} : zw;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [4:0] addr, input logic [15:0] data);
    exp_t e;
    e.idx = idx; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      low_run = 0; high_run = 0; seen_low = 0;
      prev_nruen = 1'b1; prev_gnt = '0; prev_raddr = raddr;
      return;
    end
    chk("gnt_onehot", 32'($onehot0(gnt)), 1);
    chk("gnt_done_overlap", 32'(gnt & done), 0);
    if (!nruen && !prev_nruen) chk("raddr_stable", 32'(raddr), 32'(prev_raddr));
    if (gnt != '0 && prev_gnt == '0) begin
      if (q.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
      else begin
        chk("gnt_idx", 32'(gnt), 32'(1) << q[0].idx);
        chk("gnt_addr", 32'(raddr), 32'(q[0].addr));
        chk("nruen_at_gnt", 32'(nruen), 0);
      end
    end
    if (done != '0) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        e = q.pop_front();
        chk("done_idx", 32'(done), 32'(1) << e.idx);
        chk("rdata", 32'(rdata), 32'(e.data));
        chk("ibus_released", 32'(ibus), 32'(zw));
        done_cyc.push_back(cyc);
        ndone++;
        if (auto_drop) req = req & ~done;
      end
    end
    if (nruen) begin
      if (!prev_nruen) begin
        chk("low_len", 32'(low_run), HOLD);
        low_run = 0;
      end
      high_run++;
    end else begin
      if (prev_nruen) begin
        if (seen_low) chk("gap_len", 32'(high_run >= TURN + 1), 1);
        high_run = 0;
      end
      low_run++;
      seen_low = 1;
    end
    prev_nruen = nruen; prev_raddr = raddr; prev_gnt = gnt;
  endtask

  task automatic wait_dones(input int n);
    int start;
    start = ndone;
    for (int t = 0; t < 200 && ndone < start + n; t++) tick();
    chk("done_count", 32'(ndone - start), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) req_addr[5*i +: 5] = 5'(4 + i);
    do_reset();
    chk("rst_nruen", 32'(nruen), 1);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);

    // single request on 0, grant latency one edge
    push(0, 5'd4, 16'h0000);
    req[0] = 1'b1;
    tick();
    chk("latency_gnt", 32'(gnt), 1);
    wait_dones(1);

    // single request on 1, slot 7
    req_addr[5 +: 5] = 5'd7;
    push(1, 5'd7, 16'h0003);
    req[1] = 1'b1;
    wait_dones(1);
    req_addr[5 +: 5] = 5'd5;

    // all four at once from a fresh pointer
    do_reset();
    done_cyc.delete();
    for (int i = 0; i < NREQ; i++) push(i, 5'(4 + i), 16'(i));
    req = '1;
    wait_dones(4);
    for (int i = 1; i < 4; i++) chk("done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 4);

    // 0 and 2 held continuously alternate
    do_reset();
    auto_drop = 0;
    push(0, 5'd4, 16'h0000); push(2, 5'd6, 16'h0002);
    push(0, 5'd4, 16'h0000); push(2, 5'd6, 16'h0002);
    req = 4'b0101;
    wait_dones(4);
    req = '0;
    auto_drop = 1;
    tick(); tick();

    // reset during the second DRIVE cycle aborts the transfer
    push(0, 5'd4, 16'h0000);
    req[0] = 1'b1;
    tick();
    chk("abort_gnt", 32'(gnt), 1);
    tick();
    reset = 1'b1;
    req = '0;
    tick();
    chk("abort_nruen", 32'(nruen), 1);
    chk("abort_gnt_clr", 32'(gnt), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rdata", 32'(rdata), 0);
    reset = 1'b0;
    q.delete();
    tick();
    push(0, 5'd4, 16'h0000); push(3, 5'd7, 16'h0003);
    req = 4'b1001;
    wait_dones(2);

    // address outside the store captures a floating bus
    req_addr[5 +: 5] = 5'd8;
    push(1, 5'd8, zw);
    req[1] = 1'b1;
    wait_dones(1);
    push(2, 5'd6, 16'h0002);
    req[2] = 1'b1;
    wait_dones(1);
    tick(); tick();
    chk("queue_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/ibus_read_arbiter.md
# ibus_read_arbiter

Round-robin arbiter and sequencer for the register read unit. Several requesters each want one word from a read-unit address, such as a constant-store slot. The block grants the shared `nruen`/`raddr` pair to one requester at a time and holds the address stable while the unit drives `ibus`. It captures the word, returns it with a one-cycle completion pulse, and then enforces a bus-turnaround gap before the next grant.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2–8).
- `HOLD`, 2: cycles `nruen` stays low per transfer (≥1); `ibus` is sampled at the end of the last one.
- `TURN`, 1: idle cycles with `nruen` high between transfers (≥1).

Ports:
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NREQ: per-requester request level.
- `req_addr`  in  5*NREQ: requester i's read address in bits [5i+4:5i].
- `gnt`  out  NREQ: one-hot; high for the whole transfer owned by requester i.
- `done`  out  NREQ: one-cycle pulse when requester i's data is valid on `rdata`.
- `rdata`  out  16: captured `ibus` word; holds until the next capture.
- `nruen`  out  1: active-low read-unit enable.
- `raddr`  out  5: read-unit address.
- `ibus`  in  16: data bus driven by the read unit.

## Operation
- Reset values: `nruen`=1, `raddr`=0, `gnt`=0, `done`=0, `rdata`=0. State is IDLE, the priority pointer is 0 and counters are 0.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If any `req` is high, pick the first asserted index searching from the pointer upward, wrapping mod NREQ.
  - Next edge: latch `raddr` from that requester's `req_addr`, set its `gnt` bit, drive `nruen`=0, load the counter with HOLD-1, and go to DRIVE.
  - The pointer becomes (winner+1) mod NREQ.
- DRIVE:
  - `raddr`, `gnt` and `nruen`=0 are held constant; the counter decrements each cycle.
  - On the edge where the counter is 0: `rdata` ← `ibus` (X/Z captured verbatim), `done[winner]`=1, `gnt`=0, `nruen`=1.
  - Then load the turn counter with TURN-1 and go to TURN.
- TURN:
  - `nruen`=1 and `raddr` holds its last value.
  - Requests are not evaluated; `done` clears after one cycle.
  - When the counter reaches 0, go to IDLE.
- Requester rules:
  - Requesters must hold `req` and `req_addr` until their `done`.
  - `req_addr` is sampled only at grant.
  - Dropping `req` mid-transfer does not abort; the transfer completes and `done` still pulses.
  - A requester re-asserting `req` immediately after `done` rejoins round-robin behind the others.
- Simultaneous requests: exactly one grant; the others wait without starvation. Worst-case wait is (NREQ-1)·(1+HOLD+TURN) cycles.
- Reset asserted in any state overrides everything on that edge. An in-flight transfer is aborted without a `done` and all outputs return to reset values.
- `done` and `gnt` are never both high for the same index in the same cycle. At most one `gnt` bit is ever high.

## Timing
- Request seen high at edge k (state IDLE) → `gnt`/`nruen`=0/`raddr` valid after edge k+1.
- `ibus` sampled at edge k+1+HOLD; `done` and `rdata` valid in the following cycle.
- `nruen` low for exactly HOLD cycles per transfer and high for at least TURN+1 cycles between transfers (TURN cycles plus one IDLE cycle).
- `raddr` changes only on the edge that asserts `nruen` low, never while it is low. The read unit therefore sees a stable address for its whole decode time (30 ns settle at the 63.5 ns cycle used in the CPU bench).
- Back-to-back throughput: one transfer per 1+HOLD+TURN cycles (4 at defaults).

## Test plan
Benches pair the arbiter with `constant_store` on `ibus` and use the default parameters.
- Single request, req0 with addr 5'b00100 → `nruen` low for 2 cycles, `raddr`=00100, `done[0]` pulse, `rdata`=16'h0000.
- Single request, req1 with addr 5'b00111 → `rdata`=16'h0003; `ibus` returns to Z once `nruen`=1.
- All four requesting simultaneously with addrs 4, 5, 6, 7 → grant order 0, 1, 2, 3. `rdata` sequence 0000, 0001, 0002, 0003, one `done` every 4 cycles.
- req0 and req2 held continuously → grants alternate 0, 2, 0, 2. `nruen` high ≥2 cycles between each low window and `raddr` never changes while `nruen`=0.
- Reset asserted during the second DRIVE cycle → next edge gives `nruen`=1, `gnt`=0, no `done`, `rdata`=0. The pointer resets, so a subsequent req3+req0 grants 0 first.
- Address outside the store (5'b01000) → `rdata` captures 16'hzzzz. `done` still pulses and sequencing is unaffected.
